// File: rtl/dct_block_loader_if.sv
// Pixel-stream and DCT-side signal bundle for dct_block_loader.
// The master modport is the environment (pixel source plus DCT core).
// The slave modport is the loader itself.
interface dct_block_loader_if #(
  parameter int PIX_W = 8,
  parameter int BLK_N = 8
);

  // Upstream pixel stream
  logic                               in_valid;
  logic                               in_ready;
  logic [PIX_W-1:0]                   in_pix;
  logic                               in_sob;

  // Downstream DCT block presentation
  logic [BLK_N*BLK_N*(PIX_W+1)-1:0]   out_x;
  logic                               out_start;
  logic                               dct_xfc;

  // Status
  logic                               sync_err;
  logic                               busy;

  modport master (
    output in_valid, in_pix, in_sob, dct_xfc,
    input  in_ready, out_x, out_start, sync_err, busy
  );

  modport slave (
    input  in_valid, in_pix, in_sob, dct_xfc,
    output in_ready, out_x, out_start, sync_err, busy
  );

endinterface

// File: rtl/dct_block_loader.sv
// dct_block_loader: gathers a raster pixel stream into 8x8 blocks held in a
// ping-pong pair of sample banks and hands each finished block to the DCT.
// A start-of-block marker that arrives mid-block throws away the partial
// block and restarts filling at index 0, flagging sync_err one cycle later.
// A presented block stays frozen on out_x until the DCT reports transfer
// complete, while the other bank keeps filling.
//
// Optional feature macro: DCT_LOADER_LEVEL_SHIFT_EN
//   defined   -> samples are pixel - 2^(PIX_W-1) (signed, centred on zero)
//   undefined -> samples are the zero-extended pixel (DCT removes DC itself)
module dct_block_loader #(
  parameter int PIX_W = 8,
  parameter int BLK_N = 8
) (
  input  logic               clock,
  input  logic               reset,
  dct_block_loader_if.slave  bus
);

  localparam int NS = BLK_N * BLK_N;
  localparam int SW = PIX_W + 1;
  localparam int IW = $clog2(NS);
  localparam int XW = NS * SW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Sample storage is deliberately left out of reset; the full flags gate it
  logic [SW-1:0]  r_bank [2][NS];
  logic [1:0]     r_full;
  logic           r_wrBank;
  logic           r_rdBank;
  logic [IW-1:0]  r_wrIdx;
  logic [1:0]     r_state;
  logic           r_syncErr;

  logic           w_inReady;
  logic           w_accept;
  logic           w_resync;
  logic           w_fillDone;
  logic           w_release;
  logic [IW-1:0]  w_wrAddr;
  logic [SW-1:0]  w_sample;
  logic [1:0]     w_setMask;
  logic [1:0]     w_clrMask;
  logic [1:0]     w_stateNext;
  logic [XW-1:0]  w_outX;

  assign w_inReady  = !r_full[r_wrBank];
  assign w_accept   = bus.in_valid && w_inReady;
  assign w_resync   = w_accept && bus.in_sob && (r_wrIdx != '0);
  assign w_wrAddr   = w_resync ? '0 : r_wrIdx;
  assign w_fillDone = w_accept && !w_resync && (r_wrIdx == IW'(NS - 1));
  assign w_release  = (r_state == ST_WAIT) && bus.dct_xfc;

  assign w_setMask  = w_fillDone ? (2'b01 << r_wrBank) : 2'b00;
  assign w_clrMask  = w_release  ? (2'b01 << r_rdBank) : 2'b00;

  // Convert the incoming pixel to a DCT input sample
  always_comb begin
`ifdef DCT_LOADER_LEVEL_SHIFT_EN
    w_sample = {1'b0, bus.in_pix} - SW'(1 << (PIX_W - 1));
`else
    w_sample = {1'b0, bus.in_pix};
`endif
  end

  // Write each accepted sample into the filling bank
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_bank[r_wrBank][w_wrAddr] <= w_sample;
    end
  end

  // Advance the fill pointer, restarting on a misaligned start-of-block
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrIdx  <= '0;
      r_wrBank <= 1'b0;
    end else if (w_accept) begin
      if (w_resync) begin
        r_wrIdx <= IW'(1);
      end else if (w_fillDone) begin
        r_wrIdx  <= '0;
        r_wrBank <= ~r_wrBank;
      end else begin
        r_wrIdx <= r_wrIdx + IW'(1);
      end
    end
  end

  // Fill completion and DCT release touch different banks, so both apply
  always_ff @(posedge clock) begin
    if (reset) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_clrMask) | w_setMask;
    end
  end

  // Dispatch sequencing: wait for a full bank, strobe start, hold until xfc
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (r_full[r_rdBank]) w_stateNext = ST_START;
      ST_START: w_stateNext = ST_WAIT;
      ST_WAIT:  if (bus.dct_xfc) w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  // Register the dispatch state and swap the read bank on release
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rdBank <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_release) begin
        r_rdBank <= ~r_rdBank;
      end
    end
  end

  // Misalignment becomes a single-cycle pulse one cycle after the accept
  always_ff @(posedge clock) begin
    if (reset) begin
      r_syncErr <= 1'b0;
    end else begin
      r_syncErr <= w_resync;
    end
  end

  // Flatten the presented bank onto out_x, zero while nothing is dispatched
  always_comb begin
    w_outX = '0;
    if (r_state != ST_IDLE) begin
      for (int i = 0; i < NS; i++) begin
        w_outX[i*SW +: SW] = r_bank[r_rdBank][i];
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_x     = w_outX;
  assign bus.out_start = (r_state == ST_START);
  assign bus.sync_err  = r_syncErr;
  assign bus.busy      = (r_state != ST_IDLE) || (|r_full);

endmodule

// File: tb/tb_dct_block_loader.sv
// Self-checking bench for dct_block_loader: randomized and directed pixel
// streams feed a block-level reference model; a monitor compares every
// cycle's handshake/status outputs and each dispatched block.
module tb_dct_block_loader;

  localparam int NS = 64;
  localparam int SW = 9;
  localparam int XW = NS * SW;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dct_block_loader_if #(.PIX_W(8), .BLK_N(8)) bus ();

  dct_block_loader #(.PIX_W(8), .BLK_N(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state
  int            nVec = 0;
  int            nFail = 0;
  logic [XW-1:0] expQ [$];
  logic [SW-1:0] cur [$];
  int            pending = 0;
  int            startIn = 0;
  bit            dispatched = 0;
  bit            syncNext = 0;
  bit            armed = 0;
  logic [XW-1:0] held = '0;

  // Environment controls
  bit   autoXfc = 0;
  logic autoPulse = 1'b0;
  logic manPulse = 1'b0;
  int   gapPct = 0;
  bit   senderDone = 0;

  assign bus.dct_xfc = autoPulse | manPulse;

  function automatic logic [SW-1:0] shiftPix(input int p);
`ifdef DCT_LOADER_LEVEL_SHIFT_EN
    return SW'(p - 128);
`else
    return SW'(p);
`endif
  endfunction

  function automatic void checkBit(input string nm, input logic act, input logic exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void checkBlock(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    int idx;
    idx = -1;
    nVec++;
    if (act !== exp) begin
      for (int i = 0; i < NS; i++) begin
        if (act[i*SW +: SW] !== exp[i*SW +: SW]) begin
          idx = i;
          break;
        end
      end
      nFail++;
      $display("[TB] FAIL %s: sample %0d got %h expected %h at %0t", nm, idx,
               act[idx*SW +: SW], exp[idx*SW +: SW], $time);
    end
  endfunction

  function automatic void resetModel();
    cur.delete();
    expQ.delete();
    pending    = 0;
    startIn    = 0;
    dispatched = 0;
    syncNext   = 0;
  endfunction

  // One accepted pixel: realign on a mid-block marker, close out full blocks
  function automatic void modelAccept(input int p, input logic s);
    logic [XW-1:0] vec;
    if (s && cur.size() != 0) begin
      cur.delete();
      syncNext = 1;
    end
    cur.push_back(shiftPix(p));
    if (cur.size() == NS) begin
      for (int i = 0; i < NS; i++) vec[i*SW +: SW] = cur[i];
      expQ.push_back(vec);
      cur.delete();
      if (pending == 0) startIn = 2;
      pending++;
    end
  endfunction

  // Monitor/scoreboard: compare this cycle, then predict the coming edge
  always @(negedge clock) begin
    if (armed) begin
      logic expStart;
      expStart = (startIn == 1);
      if (startIn > 0) startIn--;
      checkBit("in_ready", bus.in_ready, pending < 2);
      checkBit("busy", bus.busy, pending > 0);
      checkBit("sync_err", bus.sync_err, syncNext);
      syncNext = 0;
      checkBit("out_start", bus.out_start, expStart);
      if (bus.out_start) begin
        if (expQ.size() == 0) begin
          nVec++;
          nFail++;
          $display("[TB] FAIL start_no_block: got out_start=1 expected no pending block at %0t", $time);
        end else begin
          held = expQ.pop_front();
          checkBlock("block_on_start", bus.out_x, held);
        end
      end else if (dispatched) begin
        checkBlock("block_hold", bus.out_x, held);
      end else begin
        checkBlock("idle_zero", bus.out_x, {XW{1'b0}});
      end
      if (reset) begin
        resetModel();
      end else begin
        if (bus.dct_xfc && dispatched) begin
          dispatched = 0;
          pending--;
          if (pending > 0) startIn = 2;
        end
        if (bus.in_valid && bus.in_ready) modelAccept(int'(bus.in_pix), bus.in_sob);
        if (bus.out_start) dispatched = 1;
      end
    end else if (reset) begin
      resetModel();
      armed = 1;
    end
  end

  // DCT responder: after each start, wait a random latency and pulse xfc
  initial begin
    int d;
    forever begin
      @(negedge clock);
      if (bus.out_start && autoXfc) begin
        d = $urandom_range(1, 6);
        repeat (d) @(posedge clock);
        #1 autoPulse = 1'b1;
        @(posedge clock);
        #1 autoPulse = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input int p, input logic s);
    int n;
    if ($urandom_range(0, 99) < gapPct) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_pix   = 8'(p);
    bus.in_sob   = s;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.in_ready && n < 300);
    if (!bus.in_ready) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idleBus();
    bus.in_valid = 1'b0;
    bus.in_sob   = 1'b0;
  endtask

  task automatic pulseXfc();
    @(posedge clock);
    #1 manPulse = 1'b1;
    @(posedge clock);
    #1 manPulse = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Wait until every dispatched block has been released by the DCT
  task automatic checkOutput(input int budget);
    int n;
    n = 0;
    while (pending != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    nVec++;
    if (pending != 0) begin
      nFail++;
      $display("[TB] FAIL drain_timeout: got %0d blocks outstanding expected 0", pending);
    end
    waitCycles(2);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_pix   = '0;
    bus.in_sob   = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    waitCycles(2);

    // Flat mid-grey block; stray xfc while idle must be ignored
    $display("[TB] flat block");
    pulseXfc();
    autoXfc = 1;
    for (int i = 0; i < NS; i++) applyStimulus(128, i == 0);
    idleBus();
    checkOutput(200);

    // Ramp block 4*i
    $display("[TB] ramp block");
    for (int i = 0; i < NS; i++) applyStimulus(4 * i, i == 0);
    idleBus();
    checkOutput(200);

    // Three blocks offered continuously with the DCT stalled
    $display("[TB] backpressure");
    autoXfc = 0;
    senderDone = 0;
    fork
      begin
        for (int i = 0; i < 3 * NS; i++) applyStimulus($urandom_range(0, 255), (i % NS) == 0);
        idleBus();
        senderDone = 1;
      end
    join_none
    n = 0;
    while (pending < 2 && n < 600) begin
      @(negedge clock);
      n++;
    end
    waitCycles(6);
    pulseXfc();
    autoXfc = 1;
    n = 0;
    while (!senderDone && n < 600) begin
      @(negedge clock);
      n++;
    end
    nVec++;
    if (!senderDone) begin
      nFail++;
      $display("[TB] FAIL sender_stuck: got sender busy expected done");
    end
    checkOutput(400);

    // Misaligned start-of-block after 20 pixels
    $display("[TB] resync");
    for (int i = 0; i < 20; i++) applyStimulus($urandom_range(0, 255), i == 0);
    applyStimulus(77, 1'b1);
    for (int i = 0; i < NS - 1; i++) applyStimulus($urandom_range(0, 255), 1'b0);
    idleBus();
    checkOutput(200);

    // Reset while one block is waiting and the other bank is half full
    $display("[TB] reset mid-wait");
    autoXfc = 0;
    for (int i = 0; i < NS; i++) applyStimulus($urandom_range(0, 255), i == 0);
    idleBus();
    waitCycles(5);
    for (int i = 0; i < NS / 2; i++) applyStimulus($urandom_range(0, 255), i == 0);
    idleBus();
    @(posedge clock);
    #1 reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(2);
    autoXfc = 1;
    for (int i = 0; i < NS; i++) applyStimulus($urandom_range(0, 255), i == 0);
    idleBus();
    checkOutput(200);

    // Extreme pixel values at the block corners
    $display("[TB] extremes");
    for (int i = 0; i < NS; i++)
      applyStimulus((i == 0) ? 0 : ((i == NS - 1) ? 255 : $urandom_range(0, 255)), i == 0);
    idleBus();
    checkOutput(200);

    // Random traffic with gaps and occasional stray start markers
    $display("[TB] random");
    gapPct = 25;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NS; i++)
        applyStimulus($urandom_range(0, 255), (i == 0) || ($urandom_range(0, 99) < 2));
    end
    idleBus();
    gapPct = 0;
    for (int i = 0; i < NS; i++) applyStimulus($urandom_range(0, 255), i == 0);
    idleBus();
    checkOutput(600);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dct_block_loader.md
Name: dct_block_loader

Overview:
- Upstream feeder for the 8-bit 2D DCT core.
- Accepts a raster-ordered 8-bit pixel stream with valid/ready handshake and assembles 8x8 blocks in a ping-pong pair of 64-entry banks.
- Presents each complete block to the DCT as 64 signed 9-bit level-shifted samples, pulses the DCT start strobe, and holds the block stable until the DCT signals transfer complete.

Parameters:
PIX_W, 8, input pixel width; sample width is PIX_W+1
BLK_N, 8, block dimension; block holds BLK_N*BLK_N samples

Ports:
clock  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
in_valid  in  1  pixel valid
in_ready  out  1  loader can accept a pixel
in_pix  in  PIX_W  unsigned pixel
in_sob  in  1  start-of-block marker, qualified by in_valid&&in_ready
out_x  out  BLK_N*BLK_N*(PIX_W+1)  sample i at bits [9i+8:9i], signed two's complement, i = row*8+col
out_start  out  1  one-cycle DCT start pulse
dct_xfc  in  1  DCT transfer complete; releases presented block
sync_err  out  1  one-cycle pulse on in_sob misalignment
busy  out  1  any bank full or dispatch in progress

Behaviour:
- Storage: bank[2][64] of PIX_W+1 bits; full[1:0]; wr_bank, wr_idx (0..63); rd_bank.
- in_ready = !full[wr_bank] (combinational from registers).
- Accept = in_valid && in_ready. Store level-shifted sample at bank[wr_bank][wr_idx], wr_idx+1.
- Accept at wr_idx==63: full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
- in_sob on accept with wr_idx!=0: partial block discarded; pixel stored at index 0, wr_idx<=1; sync_err pulses next cycle. in_sob at wr_idx==0: normal, no error.
- Dispatch FSM, states IDLE, START, WAIT:
  - IDLE: if full[rd_bank] -> START.
  - START: out_start=1 for exactly this cycle -> WAIT.
  - WAIT: on dct_xfc -> full[rd_bank]<=0, rd_bank toggles -> IDLE.
  - dct_xfc outside WAIT is ignored.
- Latency: pixel 63 accepted in cycle t with FSM idle -> out_start high in cycle t+2.
- out_x: bank[rd_bank] contents while state is START or WAIT; all zeros in IDLE. Stable from START until the cycle after dct_xfc.
- Simultaneous events: fill completion on one bank and dct_xfc release of the other in the same cycle update both full bits independently. Freed bank gives in_ready=1 the next cycle. Back-to-back: a bank already full when WAIT exits goes IDLE->START without gap beyond the one IDLE cycle.
- Both banks full: in_ready=0, no pixel loss.
- busy = (state!=IDLE) || |full.
- Reset (any cycle, including mid-fill or mid-WAIT):
  - full=0, wr_bank=rd_bank=0, wr_idx=0, state=IDLE; partial/pending blocks discarded.
  - Outputs: in_ready=1, out_start=0, out_x=0, sync_err=0, busy=0.
  - Bank contents are not reset.

Optional Feature:
DCT_LOADER_LEVEL_SHIFT_EN
- Defined: sample = {1'b0,pix} - 128, range -128..127.
- Undefined: sample = {1'b0,pix}, range 0..255, for DCT configurations that apply DC offset internally.
- Handshake and timing are identical in both cases.

Test Plan:
1. Macro on; reset, 64 pixels of value 128 back-to-back, dct_xfc 5 cycles after start -> single out_start at t+2, out_x all zero, in_ready stays 1, busy falls after xfc.
2. Macro on; pixel i = 4*i -> out_x sample 0 = -128 (9'h180), sample 1 = -124, sample 63 = 124; values held unchanged until dct_xfc.
3. 192 pixels offered continuously, dct_xfc held low -> in_ready drops after 128th accept, one out_start only; pulse dct_xfc -> in_ready high next cycle, second out_start two cycles later, remaining 64 pixels accepted.
4. 20 pixels, then pixel with in_sob -> sync_err one-cycle pulse; out_start only after 63 further accepts, sample 0 = the in_sob pixel.
5. Assert reset during WAIT with second bank half-filled -> out_start 0, out_x 0, in_ready 1, busy 0; fresh 64 pixels yield exactly one block.
6. Macro off; pixels 0 and 255 at indices 0 and 63 -> samples 0 and 255 (9'h0FF).
